// File: rtl/gray_binary_conv_seq.sv
// Multi-cycle Gray<->binary converter. It converts BPC bits per clock, MSB first.
// A registered carry links the XOR chain from one chunk to the next.
//
// state | meaning
// IDLE  | ready for a word; in_ready=1
// CONV  | converting chunk cnt_q each cycle; N cycles total
// HOLD  | result presented on data_out with out_valid=1 until out_ready
module gray_binary_conv_seq #(
  parameter int WIDTH = 8,
  parameter int BPC   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);

  localparam int N     = (WIDTH + BPC - 1) / BPC;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             mode_q;
  logic             carry_q, carry_d;
  logic             chain_c;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             last_chunk;

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign accept     = in_valid & in_ready;
  assign last_chunk = (cnt_q == CNT_W'(N - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)     state_d = CONV;
      CONV:    if (last_chunk) state_d = HOLD;
      HOLD:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // XOR chain over the active chunk only; bits outside it keep their value
  always_comb begin
    result_d = result_q;
    chain_c  = carry_q;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (((WIDTH - 1 - i) / BPC) == int'(cnt_q)) begin
        result_d[i] = chain_c ^ word_q[i];
        chain_c     = mode_q ? word_q[i] : result_d[i];
      end
    end
    carry_d = chain_c;
  end

  // Datapath: capture on accept, step per chunk, publish on entry to HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q    <= '0;
      result_q  <= '0;
      mode_q    <= 1'b0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            word_q   <= data_in;
            mode_q   <= mode;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
          end
        end
        CONV: begin
          result_q <= result_d;
          carry_q  <= carry_d;
          cnt_q    <= cnt_q + 1'b1;
          if (last_chunk) begin
            data_out  <= result_d;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_binary_conv_seq.sv
// Bench for gray_binary_conv_seq. It uses three instances: 8/2, 5/2 and 8/8.
// Results are checked against an arithmetic Gray/binary reference model.
module tb_gray_binary_conv_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] iv, ordy, irdy, ov, bsy;
  logic [7:0] data_in;
  logic       mode;
  logic [7:0] dout0, dout2;
  logic [4:0] dout1;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  gray_binary_conv_seq #(.WIDTH(8), .BPC(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .mode(mode),
    .data_in(data_in), .out_valid(ov[0]), .out_ready(ordy[0]), .data_out(dout0), .busy(bsy[0]));

  gray_binary_conv_seq #(.WIDTH(5), .BPC(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .mode(mode),
    .data_in(data_in[4:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .data_out(dout1), .busy(bsy[1]));

  gray_binary_conv_seq #(.WIDTH(8), .BPC(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .mode(mode),
    .data_in(data_in), .out_valid(ov[2]), .out_ready(ordy[2]), .data_out(dout2), .busy(bsy[2]));

  function automatic int wid_of(logic [1:0] k);
    return (k == 2'd1) ? 5 : 8;
  endfunction

  function automatic int n_of(logic [1:0] k);
    case (k)
      2'd0:    return 4;
      2'd1:    return 3;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] dout_of(logic [1:0] k);
    case (k)
      2'd0:    return dout0;
      2'd1:    return {3'b000, dout1};
      default: return dout2;
    endcase
  endfunction

  // Reference: bin->gray is b ^ (b>>1); gray->bin is the XOR of all right shifts
  function automatic logic [7:0] ref_conv(int w, logic m, logic [7:0] d);
    logic [7:0] x, r;
    x = d & 8'((1 << w) - 1);
    if (m) r = x ^ (x >> 1);
    else begin
      r = 8'h00;
      for (int s = 0; s < w; s++) r = r ^ (x >> s);
    end
    return r;
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_accept(logic [1:0] k, logic m, logic [7:0] d);
    int guard = 0;
    iv[k] = 1'b1; data_in = d; mode = m;
    while (!irdy[k] && guard < 50) begin @(posedge clk); #1; guard++; end
    if (guard >= 50) check("accept_timeout", 8'(irdy[k]), 8'd1);
    @(posedge clk); #1;
    iv[k] = 1'b0; data_in = 8'($urandom); mode = 1'($urandom);
  endtask

  task automatic wait_valid(logic [1:0] k, output int lat);
    lat = 0;
    while (!ov[k] && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic consume(logic [1:0] k);
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
  endtask

  task automatic run_word(logic [1:0] k, logic m, logic [7:0] d, string tag, output logic [7:0] res);
    int lat;
    do_accept(k, m, d);
    wait_valid(k, lat);
    check({tag, "_lat"}, 8'(lat), 8'(n_of(k)));
    res = dout_of(k);
    check(tag, res, ref_conv(wid_of(k), m, d));
    consume(k);
  endtask

  initial begin
    logic [7:0] r, rb, hold_val;
    int lat;
    rst_n = 1'b0; iv = '0; ordy = '0; data_in = 8'h00; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_out_valid", 8'(ov[k]), 8'd0);
      check("rst_data_out", dout_of(2'(k)), 8'h00);
      check("rst_busy", 8'(bsy[k]), 8'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 8'(irdy), 8'h07);

    // Directed Gray->binary and binary->Gray words
    run_word(2'd0, 1'b0, 8'hC6, "t1_c6", r);
    check("t1_value", r, 8'h84);
    run_word(2'd0, 1'b1, 8'h84, "t2_84", r);
    check("t2_value", r, 8'hC6);

    // Exhaustive round trip on the 8/2 instance
    for (int v = 0; v < 256; v++) begin
      run_word(2'd0, 1'b0, 8'(v), "exh_g2b", r);
      run_word(2'd0, 1'b1, r, "exh_b2g", rb);
      check("exh_roundtrip", rb, 8'(v));
    end

    // Partial last chunk on the 5/2 instance
    run_word(2'd1, 1'b0, 8'h1F, "t3_1f", r);
    check("t3_value", r, 8'h15);
    for (int i = 0; i < 40; i++)
      run_word(2'd1, 1'($urandom), 8'($urandom), "rnd_w5", r);

    // Backpressure: HOLD persists with in_valid asserted
    do_accept(2'd0, 1'b0, 8'hFF);
    wait_valid(2'd0, lat);
    check("t4_lat", 8'(lat), 8'd4);
    hold_val = ref_conv(8, 1'b0, 8'hFF);
    check("t4_value", dout0, hold_val);
    iv[0] = 1'b1; data_in = 8'hFF; mode = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("t4_hold_data", dout0, hold_val);
      check("t4_hold_in_ready", 8'(irdy[0]), 8'd0);
      check("t4_hold_out_valid", 8'(ov[0]), 8'd1);
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    check("t4_idle_in_ready", 8'(irdy[0]), 8'd1);
    check("t4_idle_out_valid", 8'(ov[0]), 8'd0);
    check("t4_idle_busy", 8'(bsy[0]), 8'd0);
    check("t4_data_kept", dout0, hold_val);

    // Reset while cnt=1 in CONV
    do_accept(2'd0, 1'b0, 8'h5A);
    @(posedge clk); #1;
    check("t5_busy_conv", 8'(bsy[0]), 8'd1);
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", 8'(ov[0]), 8'd0);
    check("t5_data_out", dout0, 8'h00);
    check("t5_busy", 8'(bsy[0]), 8'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_in_ready", 8'(irdy[0]), 8'd1);
    run_word(2'd0, 1'b0, 8'h5A, "t5_after", r);

    // Single-cycle conversion, back to back
    run_word(2'd2, 1'b0, 8'h01, "t6_01", r);
    check("t6_value_01", r, 8'h01);
    run_word(2'd2, 1'b0, 8'h80, "t6_80", r);
    check("t6_value_80", r, 8'hFF);
    for (int i = 0; i < 20; i++)
      run_word(2'd2, 1'($urandom), 8'($urandom), "rnd_w8b8", r);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
